decode_ctrl_pipe: RTL and testbench
===================================

// Module: decode_ctrl_pipe
// PURPOSE
//   Registered RV32I instruction decoder: turns a fetched instruction into the
//   control bundle (ALU op, operand select, memory, branch/jump, writeback)
//   plus expanded immediate and register indices for the execute stage.
//   Sits between fetch and execute as one pipeline stage with valid/ready
//   handshake, stall, flush and illegal-instruction detection.
// PARAMETERS
//   XLEN   32  datapath width; immediates sign-extended to XLEN (XLEN >= 32)
//   RV32E  0   1: any used register index > 15 is flagged illegal
// PORTS
//   clk          in   1     clock, all state on rising edge
//   rst          in   1     asynchronous reset, active-high
//   in_valid     in   1     in_instr valid this cycle
//   in_ready     out  1     stage can accept in_instr this cycle
//   in_instr     in   32    raw instruction
//   flush        in   1     kill held and incoming instruction
//   out_valid    out  1     decoded bundle valid
//   out_ready    in   1     execute consumes bundle this cycle
//   alu_op       out  4     {variant bit, funct3}, encoding below
//   alu_src_imm  out  1     ALU operand B = imm
//   reg_write    out  1     write rd
//   mem_read     out  1     load
//   mem_write    out  1     store
//   mem_size     out  3     funct3 of load/store
//   branch       out  1     conditional branch, cond = funct3
//   jump         out  1     JAL/JALR
//   rs1,rs2,rd   out  5ea   register indices (rs1 forced 0 for LUI)
//   imm          out  XLEN  sign-extended immediate
//   illegal      out  1     instruction not decodable
// BEHAVIOUR
//   - Reset: out_valid=0 and every bundle output 0; in_ready=1 after reset.
//   - in_ready = !out_valid | out_ready (combinational). Capture when
//     in_valid & in_ready; bundle appears with out_valid=1 the next cycle
//     (latency 1, throughput 1/cycle with out_ready held high).
//   - out_valid=1 & out_ready=0: all outputs held stable, in_ready=0.
//   - Consume without new capture: out_valid->0; bundle fields keep last value.
//   - flush=1: out_valid=0 next cycle; capture that cycle suppressed even if
//     in_valid&in_ready (flush wins over capture and hold).
//   - Decode by opcode: R 0110011 alu_op={f7[5],f3}, reg_write; I 0010011
//     alu_op={f3==101 ? instr[30] : 0, f3}, alu_src_imm, reg_write;
//     LOAD 0000011, STORE 0100011, JALR 1100111, JAL 1101111, AUIPC 0010111,
//     LUI 0110111: alu_op=0000 (ADD); BRANCH 1100011: alu_op=1000 (SUB).
//   - imm by format: I instr[31:20]; S {[31:25],[11:7]}; B {[31],[7],[30:25],
//     [11:8],0}; U {[31:12],12'b0}; J {[31],[19:12],[20],[30:21],0}; R: 0.
//   - Illegal when: instr[1:0]!=11; unknown opcode; R f7 not 0000000/0100000,
//     or 0100000 with f3 not 000/101; I shift f7 not 0000000 (f3=001) or not
//     0000000/0100000 (f3=101); LOAD f3 in {011,110,111}; STORE f3>010;
//     BRANCH f3 in {010,011}; JALR f3!=000; RV32E=1 and used index>15.
//     FENCE/SYSTEM are illegal in this block.
//   - illegal=1: reg_write, mem_read, mem_write, branch, jump all 0; bundle
//     still delivered with out_valid=1 so execute raises the trap.
//   - Async rst mid-stall or mid-flush: outputs to reset values immediately.
// TESTING
//   - add x3,x1,x2 0x002081B3, in_valid 1 cycle -> next cycle out_valid=1,
//     alu_op=0000, reg_write=1, rs1=1, rs2=2, rd=3, illegal=0.
//   - sub 0x402081B3 -> alu_op=1000; srai x5,x6,3 0x40335293 -> alu_op=1101,
//     alu_src_imm=1, imm=0x00000403.
//   - lw x1,-4(x2) 0xFFC12083 -> mem_read=1, mem_size=010, imm=0xFFFFFFFC;
//     beq 0xFE000EE3 -> branch=1, alu_op=1000, imm=0xFFFFFFFC.
//   - 0x00000000 and 0x0020A1B3|f7=0x01 -> illegal=1, all enables 0, out_valid=1.
//   - Back-to-back stream, out_ready=0 for 3 cycles -> in_ready=0, bundle
//     unchanged; out_ready=1 -> one bundle per cycle, none dropped/duplicated.
//   - flush during stall with in_valid=1 -> out_valid=0 next cycle, no capture;
//     rst pulse mid-stream -> out_valid=0 and bundle zero within same cycle.

Source files
------------

// File: rtl/decode_ctrl_pipe.sv
// ---------------------------------------------------------------------------
// decode_ctrl_pipe
//   Registered RV32I decode stage sitting between fetch and execute. A fetched
//   instruction is captured on a valid/ready handshake and turned into the
//   execute control bundle: ALU op, operand-B select, memory and branch/jump
//   controls, writeback enable, register indices, the sign-extended immediate
//   and an illegal-instruction flag. Illegal instructions are still delivered
//   with every side-effecting enable cleared, so execute can raise the trap.
//
// Parameters
//   XLEN   datapath width, immediates sign-extended to XLEN (XLEN >= 32)
//   RV32E  1: any register index the instruction uses above 15 is illegal
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   fetch-side handshake, in_instr is the raw instruction
//   flush               kills the held bundle and any incoming instruction
//   out_valid/out_ready execute-side handshake for the decoded bundle
//   alu_op              {variant bit, funct3}
//   alu_src_imm         ALU operand B is imm
//   reg_write           write rd
//   mem_read, mem_write load / store, mem_size is their funct3
//   branch, jump        conditional branch (cond = funct3) / JAL, JALR
//   rs1, rs2, rd        register indices (rs1 forced to 0 for LUI)
//   imm                 sign-extended immediate
//   illegal             instruction not decodable by this stage
// ---------------------------------------------------------------------------
module decode_ctrl_pipe #(
    parameter int XLEN  = 32,
    parameter bit RV32E = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      alu_op,
    output logic            alu_src_imm,
    output logic            reg_write,
    output logic            mem_read,
    output logic            mem_write,
    output logic [2:0]      mem_size,
    output logic            branch,
    output logic            jump,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_IMM    = 7'b0010011,
        OP_AUIPC  = 7'b0010111,
        OP_STORE  = 7'b0100011,
        OP_REG    = 7'b0110011,
        OP_LUI    = 7'b0110111,
        OP_BRANCH = 7'b1100011,
        OP_JALR   = 7'b1100111,
        OP_JAL    = 7'b1101111
    } opcode_e;

    typedef struct packed {
        logic [3:0]      alu_op;
        logic            alu_src_imm;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic [2:0]      mem_size;
        logic            branch;
        logic            jump;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic            illegal;
    } bundle_t;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    bundle_t bundle_d;
    bundle_t bundle_q;
    logic    valid_q;
    logic    capture;

    // ------------------------------------------------------------------
    // Field extraction and immediate formats
    // ------------------------------------------------------------------
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;

    assign f3    = in_instr[14:12];
    assign f7    = in_instr[31:25];
    assign imm_i = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
    assign imm_s = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b = {{(XLEN-13){in_instr[31]}}, in_instr[31], in_instr[7],
                    in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u = {{(XLEN-32){in_instr[31]}}, in_instr[31:12], 12'b0};
    assign imm_j = {{(XLEN-21){in_instr[31]}}, in_instr[31], in_instr[19:12],
                    in_instr[20], in_instr[30:21], 1'b0};

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic legal;
    logic use_rs1;
    logic use_rs2;
    logic use_rd;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        bundle_d     = '0;
        bundle_d.rs1 = in_instr[19:15];
        bundle_d.rs2 = in_instr[24:20];
        bundle_d.rd  = in_instr[11:7];
        legal        = (in_instr[1:0] == 2'b11);
        use_rs1      = 1'b0;
        use_rs2      = 1'b0;
        use_rd       = 1'b0;

        case (in_instr[6:0])
            OP_REG: begin
                bundle_d.alu_op    = {f7[5], f3};
                bundle_d.reg_write = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_rd  = 1'b1;
                // Only SUB and SRA have the alternate funct7 encoding.
                if (!(f7 == F7_ZERO ||
                      (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101))))
                    legal = 1'b0;
            end
            OP_IMM: begin
                // Bit 30 selects SRAI over SRLI; for other funct3 it is
                // part of the immediate and must not alter the op.
                bundle_d.alu_op      = {(f3 == 3'b101) ? in_instr[30] : 1'b0, f3};
                bundle_d.alu_src_imm = 1'b1;
                bundle_d.reg_write   = 1'b1;
                bundle_d.imm         = imm_i;
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
                if (f3 == 3'b001 && f7 != F7_ZERO)
                    legal = 1'b0;
                if (f3 == 3'b101 && f7 != F7_ZERO && f7 != F7_ALT)
                    legal = 1'b0;
            end
            OP_LOAD: begin
                bundle_d.alu_src_imm = 1'b1;
                bundle_d.reg_write   = 1'b1;
                bundle_d.mem_read    = 1'b1;
                bundle_d.mem_size    = f3;
                bundle_d.imm         = imm_i;
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
                if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111)
                    legal = 1'b0;
            end
            OP_STORE: begin
                bundle_d.alu_src_imm = 1'b1;
                bundle_d.mem_write   = 1'b1;
                bundle_d.mem_size    = f3;
                bundle_d.imm         = imm_s;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                if (f3 > 3'b010)
                    legal = 1'b0;
            end
            OP_BRANCH: begin
                bundle_d.alu_op = 4'b1000;
                bundle_d.branch = 1'b1;
                bundle_d.imm    = imm_b;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                if (f3 == 3'b010 || f3 == 3'b011)
                    legal = 1'b0;
            end
            OP_JALR: begin
                bundle_d.alu_src_imm = 1'b1;
                bundle_d.reg_write   = 1'b1;
                bundle_d.jump        = 1'b1;
                bundle_d.imm         = imm_i;
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
                if (f3 != 3'b000)
                    legal = 1'b0;
            end
            OP_JAL: begin
                bundle_d.alu_src_imm = 1'b1;
                bundle_d.reg_write   = 1'b1;
                bundle_d.jump        = 1'b1;
                bundle_d.imm         = imm_j;
                use_rd = 1'b1;
            end
            OP_AUIPC: begin
                bundle_d.alu_src_imm = 1'b1;
                bundle_d.reg_write   = 1'b1;
                bundle_d.imm         = imm_u;
                use_rd = 1'b1;
            end
            OP_LUI: begin
                // rs1 = x0 lets execute compute x0 + imm with the ADD path.
                bundle_d.alu_src_imm = 1'b1;
                bundle_d.reg_write   = 1'b1;
                bundle_d.imm         = imm_u;
                bundle_d.rs1         = 5'd0;
                use_rd = 1'b1;
            end
            default: begin
                // FENCE, SYSTEM and anything unknown.
                legal = 1'b0;
            end
        endcase

        if (RV32E && ((use_rs1 && bundle_d.rs1[4]) ||
                      (use_rs2 && bundle_d.rs2[4]) ||
                      (use_rd  && bundle_d.rd[4])))
            legal = 1'b0;

        bundle_d.illegal = !legal;
        if (!legal) begin
            bundle_d.reg_write = 1'b0;
            bundle_d.mem_read  = 1'b0;
            bundle_d.mem_write = 1'b0;
            bundle_d.branch    = 1'b0;
            bundle_d.jump      = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Pipeline register with valid/ready handshake
    // ------------------------------------------------------------------
    assign in_ready = !valid_q || out_ready;
    assign capture  = in_valid && in_ready && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the bundle fields are reset as well as valid, because the
            // stage must present an all-zero bundle straight out of reset.
            valid_q  <= 1'b0;
            bundle_q <= '0;
        end else if (flush) begin
            // Flush outranks capture; fields keep their last value.
            // NOTE: non-blocking assignments for all state, so every register
            // updates from pre-edge values regardless of statement order.
            valid_q <= 1'b0;
        end else if (capture) begin
            valid_q  <= 1'b1;
            bundle_q <= bundle_d;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid   = valid_q;
    assign alu_op      = bundle_q.alu_op;
    assign alu_src_imm = bundle_q.alu_src_imm;
    assign reg_write   = bundle_q.reg_write;
    assign mem_read    = bundle_q.mem_read;
    assign mem_write   = bundle_q.mem_write;
    assign mem_size    = bundle_q.mem_size;
    assign branch      = bundle_q.branch;
    assign jump        = bundle_q.jump;
    assign rs1         = bundle_q.rs1;
    assign rs2         = bundle_q.rs2;
    assign rd          = bundle_q.rd;
    assign imm         = bundle_q.imm;
    assign illegal     = bundle_q.illegal;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// ---------------------------------------------------------------------------
// tb_decode_ctrl_pipe
//   Self-checking bench for decode_ctrl_pipe: a table of hand-decoded
//   instructions streamed through at full rate, then directed sequences for
//   consume-without-capture, stall/backpressure, flush and async reset.
// ---------------------------------------------------------------------------
module tb_decode_ctrl_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  alu_op;
    logic        alu_src_imm;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  mem_size;
    logic        branch;
    logic        jump;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        illegal;

    decode_ctrl_pipe #(.XLEN(32), .RV32E(1'b0)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_op     (alu_op),
        .alu_src_imm(alu_src_imm),
        .reg_write  (reg_write),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_size   (mem_size),
        .branch     (branch),
        .jump       (jump),
        .rs1        (rs1),
        .rs2        (rs2),
        .rd         (rd),
        .imm        (imm),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [3:0]  alu_op;
        logic        src;
        logic        rw;
        logic        mr;
        logic        mw;
        logic [2:0]  ms;
        logic        br;
        logic        jp;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [4:0]  rdv;
        logic [31:0] immv;
        logic        ill;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] instr, input logic [3:0] alu,
                                input logic src, input logic rw, input logic mr,
                                input logic mw, input logic [2:0] ms,
                                input logic br, input logic jp,
                                input logic [4:0] r1, input logic [4:0] r2,
                                input logic [4:0] rdv, input logic [31:0] immv,
                                input logic ill);
        vec_t v;
        v.instr = instr; v.alu_op = alu; v.src = src; v.rw = rw; v.mr = mr;
        v.mw = mw; v.ms = ms; v.br = br; v.jp = jp; v.r1 = r1; v.r2 = r2;
        v.rdv = rdv; v.immv = immv; v.ill = ill;
        return v;
    endfunction

    function automatic logic [31:0] addi_k(input int k);
        logic [31:0] kk;
        kk = k;
        return (kk << 20) | (kk << 7) | 32'h13;   // addi xk, x0, k
    endfunction

    localparam int NV = 17;
    localparam int NS = 8;
    vec_t vecs [NV];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cyc;
        int idx;
        int consumed;
        int exp_rd;
        logic [4:0] held_rd;
        logic [31:0] held_imm;
        logic stall;
        int q[$];

        //            instr          alu    src rw mr mw ms      br jp r1  r2  rd  imm            ill
        vecs[0]  = mk(32'h002081B3, 4'b0000, 0, 1, 0, 0, 3'b000, 0, 0,  1,  2,  3, 32'h0,        0); // add
        vecs[1]  = mk(32'h402081B3, 4'b1000, 0, 1, 0, 0, 3'b000, 0, 0,  1,  2,  3, 32'h0,        0); // sub
        vecs[2]  = mk(32'h40335293, 4'b1101, 1, 1, 0, 0, 3'b000, 0, 0,  6,  3,  5, 32'h403,      0); // srai
        vecs[3]  = mk(32'hFFC12083, 4'b0000, 1, 1, 1, 0, 3'b010, 0, 0,  2, 28,  1, 32'hFFFFFFFC, 0); // lw
        vecs[4]  = mk(32'hFE000EE3, 4'b1000, 0, 0, 0, 0, 3'b000, 1, 0,  0,  0, 29, 32'hFFFFFFFC, 0); // beq
        vecs[5]  = mk(32'h00000000, 4'b0000, 0, 0, 0, 0, 3'b000, 0, 0,  0,  0,  0, 32'h0,        1); // all zero
        vecs[6]  = mk(32'h0220A1B3, 4'b0010, 0, 0, 0, 0, 3'b000, 0, 0,  1,  2,  3, 32'h0,        1); // f7=01
        vecs[7]  = mk(32'h00512423, 4'b0000, 1, 0, 0, 1, 3'b010, 0, 0,  2,  5,  8, 32'h8,        0); // sw
        vecs[8]  = mk(32'h123453B7, 4'b0000, 1, 1, 0, 0, 3'b000, 0, 0,  0,  3,  7, 32'h12345000, 0); // lui
        vecs[9]  = mk(32'hFF9FF0EF, 4'b0000, 1, 1, 0, 0, 3'b000, 0, 1, 31, 25,  1, 32'hFFFFFFF8, 0); // jal
        vecs[10] = mk(32'hFFF00093, 4'b0000, 1, 1, 0, 0, 3'b000, 0, 0,  0, 31,  1, 32'hFFFFFFFF, 0); // addi -1
        vecs[11] = mk(32'h40109093, 4'b0001, 1, 0, 0, 0, 3'b000, 0, 0,  1,  1,  1, 32'h401,      1); // slli f7 bad
        vecs[12] = mk(32'h00009067, 4'b0000, 1, 0, 0, 0, 3'b000, 0, 0,  1,  0,  0, 32'h0,        1); // jalr f3=1
        vecs[13] = mk(32'h00000073, 4'b0000, 0, 0, 0, 0, 3'b000, 0, 0,  0,  0,  0, 32'h0,        1); // ecall
        vecs[14] = mk(32'hFE002EE3, 4'b1000, 0, 0, 0, 0, 3'b000, 0, 0,  0,  0, 29, 32'hFFFFFFFC, 1); // branch f3=2
        vecs[15] = mk(32'hFFC13083, 4'b0000, 1, 0, 0, 0, 3'b011, 0, 0,  2, 28,  1, 32'hFFFFFFFC, 1); // ld
        vecs[16] = mk(32'h00001217, 4'b0000, 1, 1, 0, 0, 3'b000, 0, 0,  0,  0,  4, 32'h1000,     0); // auipc

        rst = 1'b1; in_valid = 1'b0; in_instr = '0; flush = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        check("reset out_valid", out_valid, 0);
        check("reset in_ready", in_ready, 1);
        check("reset imm", imm, 0);
        check("reset rd", rd, 0);
        check("reset reg_write", reg_write, 0);
        rst = 1'b0;
        tick();
        check("post-reset out_valid", out_valid, 0);

        // Full-rate stream of the table, one vector per cycle.
        out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            in_valid = 1'b1;
            in_instr = vecs[i].instr;
            tick();
            check($sformatf("v%0d out_valid", i), out_valid, 1);
            check($sformatf("v%0d alu_op", i), alu_op, vecs[i].alu_op);
            check($sformatf("v%0d alu_src_imm", i), alu_src_imm, vecs[i].src);
            check($sformatf("v%0d reg_write", i), reg_write, vecs[i].rw);
            check($sformatf("v%0d mem_read", i), mem_read, vecs[i].mr);
            check($sformatf("v%0d mem_write", i), mem_write, vecs[i].mw);
            check($sformatf("v%0d mem_size", i), mem_size, vecs[i].ms);
            check($sformatf("v%0d branch", i), branch, vecs[i].br);
            check($sformatf("v%0d jump", i), jump, vecs[i].jp);
            check($sformatf("v%0d rs1", i), rs1, vecs[i].r1);
            check($sformatf("v%0d rs2", i), rs2, vecs[i].r2);
            check($sformatf("v%0d rd", i), rd, vecs[i].rdv);
            check($sformatf("v%0d imm", i), imm, vecs[i].immv);
            check($sformatf("v%0d illegal", i), illegal, vecs[i].ill);
        end

        // Consume with no new capture: valid drops, fields hold.
        in_valid = 1'b0;
        tick();
        check("drain out_valid", out_valid, 0);
        check("drain rd kept", rd, vecs[NV-1].rdv);
        check("drain imm kept", imm, vecs[NV-1].immv);

        // Back-to-back stream with a 3-cycle stall, scoreboarded by rd tag.
        idx = 0; consumed = 0; cyc = 0; held_rd = '0; held_imm = '0;
        while (consumed < NS && cyc < 100) begin
            stall     = (cyc >= 4 && cyc < 7);
            out_ready = !stall;
            in_valid  = (idx < NS);
            in_instr  = addi_k(idx + 1);
            #1;
            if (stall) begin
                check($sformatf("stall c%0d out_valid", cyc), out_valid, 1);
                check($sformatf("stall c%0d in_ready", cyc), in_ready, 0);
                if (cyc > 4) begin
                    check($sformatf("stall c%0d rd held", cyc), rd, held_rd);
                    check($sformatf("stall c%0d imm held", cyc), imm, held_imm);
                end
            end
            if (out_valid && out_ready) begin
                exp_rd = (q.size() > 0) ? q.pop_front() : -1;
                check($sformatf("stream c%0d rd", cyc), rd, exp_rd);
                check($sformatf("stream c%0d imm", cyc), imm, exp_rd);
                consumed++;
            end
            if (in_valid && in_ready) begin
                q.push_back(idx + 1);
                idx++;
            end
            held_rd  = rd;
            held_imm = imm;
            @(posedge clk);
            #1;
            cyc++;
        end
        check("stream consumed", consumed, NS);
        check("stream leftovers", q.size(), 0);
        check("stream cycles", cyc, NS + 4);
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("stream idle out_valid", out_valid, 0);

        // Flush during stall with a new instruction offered.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = addi_k(9);
        tick();
        check("flush setup out_valid", out_valid, 1);
        check("flush setup rd", rd, 9);
        in_instr = addi_k(10);
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush out_valid", out_valid, 0);
        check("flush no capture rd", rd, 9);
        tick();
        check("flush after out_valid", out_valid, 0);

        // Flush while empty: capture suppressed even with in_ready=1.
        in_valid = 1'b1;
        in_instr = addi_k(12);
        flush    = 1'b1;
        #1;
        check("flush empty in_ready", in_ready, 1);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush empty out_valid", out_valid, 0);
        check("flush empty rd", rd, 9);

        // Async reset mid-stream clears immediately, without a clock edge.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = addi_k(11);
        tick();
        check("rst setup out_valid", out_valid, 1);
        check("rst setup rd", rd, 11);
        rst = 1'b1;
        #1;
        check("async rst out_valid", out_valid, 0);
        check("async rst rd", rd, 0);
        check("async rst imm", imm, 0);
        check("async rst reg_write", reg_write, 0);
        check("async rst in_ready", in_ready, 1);
        in_valid = 1'b0;
        #1;
        rst = 1'b0;
        tick();
        check("after rst out_valid", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
